// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file and its clear engine.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;

   // Architectural zero register index; never written, never busy.
   localparam int REG_ZERO = 0;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks indices 1..2**ADDR_W-1, one register per cycle.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   clr_state_t        state;
   logic [ADDR_W-1:0] idx;

   // Register 0 is hardwired, so the walk starts at 1 and stops at the top index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= CLR_IDLE;
         idx      <= '0;
         clr_busy <= 1'b0;
      end else begin
         case (state)
            CLR_IDLE: begin
               if (clr_req) begin
                  state    <= CLR_RUN;
                  idx      <= ADDR_W'(1);
                  clr_busy <= 1'b1;
               end
            end
            CLR_RUN: begin
               if (idx == LAST_IDX) begin
                  state    <= CLR_IDLE;
                  idx      <= '0;
                  clr_busy <= 1'b0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            default: begin
               state    <= CLR_IDLE;
               idx      <= '0;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we  = clr_busy;
   assign clr_idx = idx;

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port register file with per-register busy scoreboard and clear engine.
// Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module scoreboard_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     clr_req,
   output logic                     clr_busy
);

   localparam int              DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             busy;

   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_ok;
   logic              alloc_ok;

   regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   assign wr_ok    = wr_en    && (wr_addr    != ZERO_A) && !clr_busy;
   assign alloc_ok = alloc_en && (alloc_addr != ZERO_A) && !clr_busy;

   // Alloc is applied after write so a same-address issue leaves the register busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs <= '0;
         busy <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (clr_we && (clr_idx == ADDR_W'(i))) begin
               regs[i] <= '0;
               busy[i] <= 1'b0;
            end else begin
               if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                  regs[i] <= wr_data;
                  busy[i] <= 1'b0;
               end
               if (alloc_ok && (alloc_addr == ADDR_W'(i))) begin
                  busy[i] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] arr_data;
      logic              arr_busy;

      assign a        = rd_addr[k*ADDR_W +: ADDR_W];
      assign arr_data = (a == ZERO_A) ? '0 : regs[a];
      assign arr_busy = (a == ZERO_A) ? 1'b0 : busy[a];

`ifdef REGFILE_BYPASS_EN
      logic fwd;
      assign fwd = wr_ok && (a == wr_addr);
      assign rd_data[k*DATA_W +: DATA_W] = fwd ? wr_data : arr_data;
      // A new producer issued alongside the write keeps the register busy.
      assign rd_busy[k] = fwd ? (alloc_ok && (alloc_addr == wr_addr)) : arr_busy;
`else
      assign rd_data[k*DATA_W +: DATA_W] = arr_data;
      assign rd_busy[k]                  = arr_busy;
`endif
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: scoreboard, zero register, clear engine, reset abort.
module tb_scoreboard_regfile;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     alloc_en;
   logic [ADDR_W-1:0]        alloc_addr;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     clr_req;
   logic                     clr_busy;

   int checks = 0;
   int errors = 0;

   scoreboard_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] d0();
      return rd_data[0 +: DATA_W];
   endfunction

   function automatic logic [DATA_W-1:0] d1();
      return rd_data[DATA_W +: DATA_W];
   endfunction

   task automatic wr(input int a, input logic [DATA_W-1:0] d);
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b0; rd_addr = '0; alloc_en = 1'b0; alloc_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      step();

      // 1. reset state on both ports
      chk("rst_clr_busy", 64'(clr_busy), 64'd0);
      for (int r = 1; r < 32; r++) begin
         rd_addr = {ADDR_W'(r), ADDR_W'(r)};
         #1;
         chk("rst_d0", 64'(d0()), 64'd0);
         chk("rst_d1", 64'(d1()), 64'd0);
         chk("rst_busy", 64'(rd_busy), 64'd0);
      end

      // 2. alloc then write r5
      alloc_en = 1'b1; alloc_addr = 5;
      step();
      alloc_en = 1'b0;
      rd_addr = {ADDR_W'(0), ADDR_W'(5)};
      #1;
      chk("alloc_busy", 64'(rd_busy[0]), 64'd1);
      wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("pre_wr_data", 64'(d0()), 64'hDEADBEEF);
      chk("pre_wr_busy", 64'(rd_busy[0]), 64'd0);
`else
      chk("pre_wr_data", 64'(d0()), 64'd0);
      chk("pre_wr_busy", 64'(rd_busy[0]), 64'd1);
`endif
      step();
      wr_en = 1'b0;
      chk("wr5_data", 64'(d0()), 64'hDEADBEEF);
      chk("wr5_busy", 64'(rd_busy[0]), 64'd0);

      // 3. alloc and write same register in one cycle
      alloc_en = 1'b1; alloc_addr = 7;
      wr(7, 32'h12);
      alloc_en = 1'b0;
      rd_addr = {ADDR_W'(7), ADDR_W'(5)};
      #1;
      chk("r7_data", 64'(d1()), 64'h12);
      chk("r7_busy", 64'(rd_busy[1]), 64'd1);

      // 4. register 0 stays zero and never busy
      alloc_en = 1'b1; alloc_addr = 0;
      wr(0, 32'hFFFFFFFF);
      alloc_en = 1'b0;
      rd_addr = '0;
      #1;
      chk("r0_data", 64'(d0()), 64'd0);
      chk("r0_busy", 64'(rd_busy), 64'd0);

      // 5. fill, clear, writes dropped, re-request ignored
      for (int r = 1; r < 32; r++) wr(r, 32'h100 + 32'(r));
      rd_addr = {ADDR_W'(31), ADDR_W'(1)};
      #1;
      chk("fill_r1", 64'(d0()), 64'h101);
      chk("fill_r31", 64'(d1()), 64'h11F);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      cnt = 0;
      while (clr_busy && cnt < 100) begin
         cnt++;
         if (cnt == 10) begin
            rd_addr = {ADDR_W'(20), ADDR_W'(9)};
            #1;
            chk("mid_r9", 64'(d0()), 64'd0);
            chk("mid_r20", 64'(d1()), 64'h114);
         end
         clr_req = (cnt == 5);
         wr_en   = (cnt == 20); wr_addr = 1; wr_data = 32'h55;
         step();
      end
      clr_req = 1'b0; wr_en = 1'b0;
      chk("clr_cycles", 64'(cnt), 64'd31);
      step();
      chk("clr_stays_idle", 64'(clr_busy), 64'd0);
      for (int r = 1; r < 32; r++) begin
         rd_addr = {ADDR_W'(r), ADDR_W'(r)};
         #1;
         chk("clr_zero", 64'(d0()), 64'd0);
         chk("clr_busy_bits", 64'(rd_busy), 64'd0);
      end

      // 6. reset aborts a clear at idx 10
      wr(20, 32'h77);
      alloc_en = 1'b1; alloc_addr = 21;
      step();
      alloc_en = 1'b0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (9) step();
      rd_addr = {ADDR_W'(21), ADDR_W'(20)};
      #1;
      chk("pre_rst_r20", 64'(d0()), 64'h77);
      chk("pre_rst_b21", 64'(rd_busy[1]), 64'd1);
      chk("pre_rst_clr", 64'(clr_busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_abort_clr", 64'(clr_busy), 64'd0);
      chk("rst_abort_r20", 64'(d0()), 64'd0);
      chk("rst_abort_b21", 64'(rd_busy[1]), 64'd0);
      #1 rst = 1'b1;
      step();
      step();
      chk("post_rst_idle", 64'(clr_busy), 64'd0);

      // write-through visibility on r3
      rd_addr = {ADDR_W'(0), ADDR_W'(3)};
      wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_data", 64'(d0()), 64'hA5);
      chk("byp_busy", 64'(rd_busy[0]), 64'd0);
`else
      chk("nobyp_data", 64'(d0()), 64'd0);
`endif
      step();
      wr_en = 1'b0;
      chk("r3_data", 64'(d0()), 64'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
